// File: rtl/lbdr_pkg.sv
// Shared definitions for the LBDR routing unit.
// Flit-type bits, Cx/Rxy bit positions, FSM states and the port bundle.
package lbdr_pkg;

  localparam int FID_HDR  = 0;
  localparam int FID_TAIL = 2;

  localparam int CX_N = 0;
  localparam int CX_E = 1;
  localparam int CX_W = 2;
  localparam int CX_S = 3;

  localparam int R_SW = 0;
  localparam int R_SE = 1;
  localparam int R_WS = 2;
  localparam int R_WN = 3;
  localparam int R_ES = 4;
  localparam int R_EN = 5;
  localparam int R_NW = 6;
  localparam int R_NE = 7;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic l;
    logic n;
    logic e;
    logic w;
    logic s;
  } ports_t;

endpackage

// File: rtl/lbdr_route_calc.sv
// Combinational LBDR route computation.
// Produces a one-hot port request or flags the destination unroutable.
module lbdr_route_calc
  import lbdr_pkg::*;
#(
  parameter int X_BITS = 2,
  parameter int Y_BITS = 2
) (
  input  logic [X_BITS+Y_BITS-1:0] cur_addr,
  input  logic [X_BITS+Y_BITS-1:0] dst_addr,
  input  logic [3:0]               cx,
  input  logic [7:0]               rxy,
  output ports_t                   route,
  output logic                     unroutable
);

  localparam int AW = X_BITS + Y_BITS;

  logic [X_BITS-1:0] cur_x;
  logic [X_BITS-1:0] dst_x;
  logic [Y_BITS-1:0] cur_y;
  logic [Y_BITS-1:0] dst_y;
  logic go_n, go_s, go_e, go_w, here;
  logic mn, me, mw, ms;

  assign cur_x = cur_addr[X_BITS-1:0];
  assign dst_x = dst_addr[X_BITS-1:0];
  assign cur_y = cur_addr[AW-1:X_BITS];
  assign dst_y = dst_addr[AW-1:X_BITS];

  assign go_n = dst_y < cur_y;
  assign go_s = dst_y > cur_y;
  assign go_e = dst_x > cur_x;
  assign go_w = dst_x < cur_x;
  assign here = dst_addr == cur_addr;

  assign mn = cx[CX_N] & (go_n & ~go_e & ~go_w
            | go_n & go_e & rxy[R_NE]
            | go_n & go_w & rxy[R_NW]);
  assign me = cx[CX_E] & (go_e & ~go_n & ~go_s
            | go_e & go_n & rxy[R_EN]
            | go_e & go_s & rxy[R_ES]);
  assign mw = cx[CX_W] & (go_w & ~go_n & ~go_s
            | go_w & go_n & rxy[R_WN]
            | go_w & go_s & rxy[R_WS]);
  assign ms = cx[CX_S] & (go_s & ~go_e & ~go_w
            | go_s & go_e & rxy[R_SE]
            | go_s & go_w & rxy[R_SW]);

  // Fixed priority L > N > E > W > S keeps the request one-hot
  // even when the turn bits permit two minimal directions.
  always_comb begin
    route      = '0;
    unroutable = 1'b0;
    if (here)    route.l = 1'b1;
    else if (mn) route.n = 1'b1;
    else if (me) route.e = 1'b1;
    else if (mw) route.w = 1'b1;
    else if (ms) route.s = 1'b1;
    else         unroutable = 1'b1;
  end

endmodule

// File: rtl/lbdr_param.sv
// LBDR routing unit: packet FSM, config registers and port outputs.
// Route is computed on a header in IDLE and held until tail release.
module lbdr_param
  import lbdr_pkg::*;
#(
  parameter int X_BITS = 2,
  parameter int Y_BITS = 2,
  parameter int FID_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [X_BITS+Y_BITS-1:0] cur_addr_rst,
  input  logic [3:0]               Cx_rst,
  input  logic [7:0]               Rxy_rst,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_cx,
  input  logic [7:0]               cfg_rxy,
  input  logic [FID_W-1:0]         flit_id,
  input  logic [X_BITS+Y_BITS-1:0] dst_addr,
  input  logic                     empty,
  input  logic                     grant,
  output logic                     Lport,
  output logic                     Nport,
  output logic                     Eport,
  output logic                     Wport,
  output logic                     Sport,
  output logic                     route_err,
  output logic                     proto_err
);

  localparam int AW = X_BITS + Y_BITS;

  state_t        state, state_n;
  ports_t        ports, ports_n;
  ports_t        route;
  logic          unroutable;
  logic          rerr_n, perr_n;
  logic          hdr_taken, hdr_taken_n;
  logic          pend_vld, pend_vld_n;
  logic [3:0]    pend_cx, pend_cx_n;
  logic [7:0]    pend_rxy, pend_rxy_n;
  logic [AW-1:0] cur_reg;
  logic [3:0]    cx_reg;
  logic [7:0]    rxy_reg;
  logic          cfg_ld;
  logic [3:0]    ld_cx;
  logic [7:0]    ld_rxy;
  logic          is_hdr, is_tail;
  logic          flit_unused;

  assign is_hdr      = flit_id[FID_HDR];
  assign is_tail     = flit_id[FID_TAIL];
  assign flit_unused = ^flit_id;

  lbdr_route_calc #(
    .X_BITS(X_BITS),
    .Y_BITS(Y_BITS)
  ) u_calc (
    .cur_addr  (cur_reg),
    .dst_addr  (dst_addr),
    .cx        (cx_reg),
    .rxy       (rxy_reg),
    .route     (route),
    .unroutable(unroutable)
  );

  // Next-state, port latch, error pulse and config-apply decisions.
  always_comb begin
    state_n     = state;
    ports_n     = ports;
    rerr_n      = route_err;
    perr_n      = 1'b0;
    hdr_taken_n = hdr_taken;
    pend_vld_n  = pend_vld;
    pend_cx_n   = pend_cx;
    pend_rxy_n  = pend_rxy;
    cfg_ld      = 1'b0;
    ld_cx       = cfg_cx;
    ld_rxy      = cfg_rxy;
    unique case (state)
      IDLE: begin
        cfg_ld = cfg_we;
        if (!empty) begin
          if (is_hdr) begin
            state_n     = BUSY;
            ports_n     = route;
            rerr_n      = unroutable;
            hdr_taken_n = 1'b0;
          end else begin
            perr_n = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cfg_we) begin
          pend_vld_n = 1'b1;
          pend_cx_n  = cfg_cx;
          pend_rxy_n = cfg_rxy;
        end
        if (!empty && grant) begin
          if (is_hdr && hdr_taken) begin
            perr_n = 1'b1;
          end else if (is_tail) begin
            state_n     = IDLE;
            ports_n     = '0;
            rerr_n      = 1'b0;
            hdr_taken_n = 1'b0;
            pend_vld_n  = 1'b0;
            if (cfg_we) begin
              cfg_ld = 1'b1;
            end else if (pend_vld) begin
              cfg_ld = 1'b1;
              ld_cx  = pend_cx;
              ld_rxy = pend_rxy;
            end
          end else if (is_hdr) begin
            hdr_taken_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, port and pending-config state with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ports     <= '0;
      route_err <= 1'b0;
      proto_err <= 1'b0;
      hdr_taken <= 1'b0;
      pend_vld  <= 1'b0;
      pend_cx   <= '0;
      pend_rxy  <= '0;
    end else begin
      state     <= state_n;
      ports     <= ports_n;
      route_err <= rerr_n;
      proto_err <= perr_n;
      hdr_taken <= hdr_taken_n;
      pend_vld  <= pend_vld_n;
      pend_cx   <= pend_cx_n;
      pend_rxy  <= pend_rxy_n;
    end
  end

  // Address and connectivity sampled while in reset, then reconfigurable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_reg <= cur_addr_rst;
      cx_reg  <= Cx_rst;
      rxy_reg <= Rxy_rst;
    end else if (cfg_ld) begin
      cx_reg  <= ld_cx;
      rxy_reg <= ld_rxy;
    end
  end

  assign Lport = ports.l;
  assign Nport = ports.n;
  assign Eport = ports.e;
  assign Wport = ports.w;
  assign Sport = ports.s;

endmodule
